spsram_stream_rd: RTL

- Reader-side companion to the single-port SRAM: accepts a (base, length) read command and streams that many words from the SRAM onto a valid/ready output stream.
- Absorbs the SRAM's fixed 1-cycle read latency and downstream back-pressure with a 2-entry credit-controlled buffer.
- Sits between an spsram instance (read port) and any stream consumer in libv.

---
 rtl/spsram_rd_pkg.sv | 24 ++
 rtl/spsram_rd_buf.sv | 76 +++++++
 rtl/spsram_stream_rd.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spsram_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spsram_rd_pkg
// Description : Shared types and constants for the SRAM stream reader.
//               FSM state encoding, buffer depth and occupancy type.
// Revision    : 1.0 - initial release
// ============================================================================
package spsram_rd_pkg;

    // Reader FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for a command, cmd_rdy_o high
        ISSUE = 2'd1,   // SRAM reads remaining
        DRAIN = 2'd2    // all reads issued, beats still pending
    } rd_state_t;

    // Depth of the output buffer; also the number of read credits
    localparam int SPSRAM_RD_BUF_N = 2;

    // Occupancy count, wide enough to hold 0..SPSRAM_RD_BUF_N
    typedef logic [$clog2(SPSRAM_RD_BUF_N + 1) - 1:0] rd_occ_t;

endpackage
`default_nettype wire

// File: rtl/spsram_rd_buf.sv
`default_nettype none
// ============================================================================
// Module      : spsram_rd_buf
// Description : 2-entry synchronous FIFO. The head entry lives in its own
//               register so the stream outputs come straight from a flop.
// Revision    : 1.0 - initial release
// Ports       : clk, rst        - clock, async active-high reset
//               push_i, din_i   - write strobe and data (tail)
//               pop_i           - remove head entry (ignored when empty)
//               dout_o, vld_o   - head data and non-empty flag
//               occ_o           - current occupancy 0..2
// ============================================================================
module spsram_rd_buf
    import spsram_rd_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          vld_o,
    output rd_occ_t       occ_o
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    rd_occ_t      occ_q;
    logic         pop_d;

    // A pop on an empty buffer is meaningless; drop it here so the
    // shift logic never pulls stale tail data forward.
    assign pop_d = pop_i && (occ_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            case ({push_i, pop_d})
                2'b10: begin
                    if (occ_q == '0) begin
                        head_q <= din_i;
                    end else begin
                        tail_q <= din_i;
                    end
                    occ_q <= occ_q + rd_occ_t'(1);
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - rd_occ_t'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes wherever
                    // the departing head leaves room.
                    if (occ_q == rd_occ_t'(1)) begin
                        head_q <= din_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout_o = head_q;
    assign vld_o  = (occ_q != '0);
    assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/spsram_stream_rd.sv
`default_nettype none
// ============================================================================
// Module      : spsram_stream_rd
// Description : Accepts a (base, length) read command and streams that many
//               words from a single-port SRAM (1-cycle read latency) onto a
//               valid/ready stream. A 2-credit scheme bounds words in the
//               buffer plus reads in flight so back-pressure never loses data.
// Revision    : 1.0 - initial release
// Ports       : clk, rst                        - clock, async active-high reset
//               cmd_vld_i/cmd_base_i/cmd_len_i  - command request
//               cmd_rdy_o                       - high while idle
//               sram_en_o/sram_addr_o           - SRAM read port request
//               sram_rdata_i                    - SRAM data, 1 cycle after en
//               out_vld_o/out_dat_o/out_last_o  - output stream
//               out_rdy_i                       - consumer ready
//               busy_o                          - command in progress
// ============================================================================
module spsram_stream_rd
    import spsram_rd_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 256,
    parameter int A = $clog2(N),
    parameter int L = A + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_vld_i,
    input  logic [A-1:0]  cmd_base_i,
    input  logic [L-1:0]  cmd_len_i,
    output logic          cmd_rdy_o,
    output logic          sram_en_o,
    output logic [A-1:0]  sram_addr_o,
    input  logic [W-1:0]  sram_rdata_i,
    output logic          out_vld_o,
    output logic [W-1:0]  out_dat_o,
    output logic          out_last_o,
    input  logic          out_rdy_i,
    output logic          busy_o
);

    localparam logic [A-1:0] c_ADDR_LAST = A'(N - 1);
    localparam logic [L-1:0] c_DEPTH     = L'(N);
    localparam logic [L-1:0] c_ONE       = L'(1);
    localparam logic [2:0]   c_CREDITS   = 3'(SPSRAM_RD_BUF_N);

    rd_state_t     state_q;
    logic [A-1:0]  ptr_q;       // next address to read
    logic [A-1:0]  addr_q;      // last address presented to the SRAM
    logic [L-1:0]  iss_cnt_q;   // reads still to issue
    logic [L-1:0]  dlv_cnt_q;   // beats still to deliver
    logic          pend_q;      // read issued last cycle, data arriving now

    logic [A-1:0]  ptr_d;
    rd_occ_t       buf_occ;
    logic          buf_vld;
    logic          pop_d;
    logic          issue_d;
    logic          cmd_hs_d;
    logic [2:0]    committed_d;

    assign pop_d    = buf_vld && out_rdy_i;
    assign cmd_hs_d = cmd_vld_i && (state_q == IDLE);

    // Words that will occupy the buffer next cycle without a new read.
    // A pop never exceeds occupancy, so this cannot underflow.
    assign committed_d = 3'(buf_occ) + {2'b00, pend_q} - {2'b00, pop_d};
    assign issue_d     = (state_q == ISSUE) && (committed_d < c_CREDITS);

    // Explicit wrap so non-power-of-two depths never address past N-1
    assign ptr_d = (ptr_q == c_ADDR_LAST) ? '0 : ptr_q + A'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            iss_cnt_q <= '0;
            dlv_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            pend_q <= issue_d;

            if (issue_d) begin
                addr_q    <= ptr_q;
                ptr_q     <= ptr_d;
                iss_cnt_q <= iss_cnt_q - c_ONE;
            end

            if (pop_d) begin
                dlv_cnt_q <= dlv_cnt_q - c_ONE;
            end

            case (state_q)
                IDLE: begin
                    // Zero-length commands are consumed without leaving IDLE
                    if (cmd_hs_d && (cmd_len_i != '0)) begin
                        state_q   <= ISSUE;
                        ptr_q     <= cmd_base_i;
                        iss_cnt_q <= cmd_len_i;
                        dlv_cnt_q <= cmd_len_i;
                    end
                end
                ISSUE: begin
                    if (issue_d && (iss_cnt_q == c_ONE)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_d && out_last_o) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    spsram_rd_buf #(
        .W(W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (pend_q),
        .din_i  (sram_rdata_i),
        .pop_i  (pop_d),
        .dout_o (out_dat_o),
        .vld_o  (buf_vld),
        .occ_o  (buf_occ)
    );

    assign cmd_rdy_o   = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign sram_en_o   = issue_d;
    // Address holds its previous value whenever no read is issued
    assign sram_addr_o = issue_d ? ptr_q : addr_q;
    assign out_vld_o   = buf_vld;
    assign out_last_o  = buf_vld && (dlv_cnt_q == c_ONE);

    a_base_legal : assert property (@(posedge clk) disable iff (rst)
        cmd_hs_d |-> ({1'b0, cmd_base_i} < c_DEPTH));

    a_len_legal : assert property (@(posedge clk) disable iff (rst)
        cmd_hs_d |-> (cmd_len_i <= c_DEPTH));

    a_credit : assert property (@(posedge clk) disable iff (rst)
        (3'(buf_occ) + {2'b00, pend_q}) <= c_CREDITS);

endmodule
`default_nettype wire
